// File: rtl/byte_reg_bank.sv
// Bank of DEPTH byte-enabled registers with per-byte written flags, a
// registered read port that sees same-cycle writes/clears, and a full flag.
module byte_reg_bank #(
  parameter  int NBYTES = 2,
  parameter  int DEPTH  = 4,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int W      = 8 * NBYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NBYTES-1:0] byteena,
  input  logic [W-1:0]      wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [W-1:0]      rdata,
  output logic              rvalid,
  output logic [NBYTES-1:0] rmask,
  output logic              full
);

  // Next-state of every word and flag set; the read port selects from these
  // so a same-cycle write or clear is visible in the returned value.
  logic [DEPTH-1:0][W-1:0]      word_nxt;
  logic [DEPTH-1:0][NBYTES-1:0] flag_nxt;
  logic [DEPTH-1:0][NBYTES-1:0] flag_cur;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [W-1:0]      word_q;
      logic [W-1:0]      word_d;
      logic [NBYTES-1:0] flag_q;
      logic [NBYTES-1:0] flag_d;
      logic              sel;

      // Addresses at or beyond DEPTH match no word, so such writes vanish.
      assign sel = we && (waddr == AW'(gi));

      always_comb begin
        word_d = word_q;
        flag_d = flag_q;
        if (clear) begin
          word_d = '0;
          flag_d = '0;
        end else if (sel) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (byteena[b]) begin
              word_d[8*b +: 8] = wdata[8*b +: 8];
              flag_d[b]        = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_q <= '0;
          flag_q <= '0;
        end else begin
          word_q <= word_d;
          flag_q <= flag_d;
        end
      end

      assign word_nxt[gi] = word_d;
      assign flag_nxt[gi] = flag_d;
      assign flag_cur[gi] = flag_q;
    end
  endgenerate

  logic [W-1:0]      rdata_q;
  logic [W-1:0]      rdata_d;
  logic [NBYTES-1:0] rmask_q;
  logic [NBYTES-1:0] rmask_d;
  logic              rvalid_q;
  logic              rvalid_d;

  // Out-of-range read addresses fall through with zero data and mask.
  always_comb begin
    rvalid_d = re;
    rdata_d  = rdata_q;
    rmask_d  = rmask_q;
    if (re) begin
      rdata_d = '0;
      rmask_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (raddr == AW'(i)) begin
          rdata_d = word_nxt[i];
          rmask_d = flag_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rmask_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rmask_q  <= rmask_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rmask  = rmask_q;
  assign rvalid = rvalid_q;
  assign full   = &flag_cur;

endmodule

// File: tb/tb_byte_reg_bank.sv
// Directed bench for byte_reg_bank: a DEPTH=4 and a DEPTH=3 instance share
// stimulus and are checked every cycle against a word/flag array model.
module tb_byte_reg_bank;

  logic        clk = 1'b0;
  logic        reset, clear, we, re;
  logic [1:0]  waddr, raddr, byteena;
  logic [15:0] wdata;

  logic [15:0] rdata4, rdata3;
  logic        rvalid4, rvalid3, full4, full3;
  logic [1:0]  rmask4, rmask3;

  always #5 clk = ~clk;

  byte_reg_bank #(.NBYTES(2), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr),
    .byteena(byteena), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata4), .rvalid(rvalid4), .rmask(rmask4), .full(full4)
  );

  byte_reg_bank #(.NBYTES(2), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .waddr(waddr),
    .byteena(byteena), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata3), .rvalid(rvalid3), .rmask(rmask3), .full(full3)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: index 0 is the DEPTH=4 bank, index 1 the DEPTH=3 bank.
  logic [15:0] mmem [2][4];
  logic [1:0]  mflg [2][4];
  logic [15:0] mrd  [2];
  logic [1:0]  mrm  [2];
  logic        mrv  [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic logic model_full(input int k);
    logic f = 1'b1;
    for (int a = 0; a < depth_of(k); a++)
      if (mflg[k][a] != 2'b11) f = 1'b0;
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4; a++) begin
        mmem[k][a] = '0;
        mflg[k][a] = '0;
      end
      mrd[k] = '0;
      mrm[k] = '0;
      mrv[k] = 1'b0;
    end
  endtask

  // One clock edge worth of state change, using the inputs held on the bus.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = depth_of(k);
      if (clear) begin
        for (int a = 0; a < 4; a++) begin
          mmem[k][a] = '0;
          mflg[k][a] = '0;
        end
      end else if (we && int'(waddr) < d) begin
        for (int b = 0; b < 2; b++) begin
          if (byteena[b]) begin
            mmem[k][waddr][8*b +: 8] = wdata[8*b +: 8];
            mflg[k][waddr][b]        = 1'b1;
          end
        end
      end
      mrv[k] = re;
      if (re) begin
        if (int'(raddr) < d) begin
          mrd[k] = mmem[k][raddr];
          mrm[k] = mflg[k][raddr];
        end else begin
          mrd[k] = '0;
          mrm[k] = '0;
        end
      end
    end
  endtask

  task automatic cyc(input logic we_i, input logic [1:0] wa, input logic [1:0] be,
                     input logic [15:0] wd, input logic re_i, input logic [1:0] ra,
                     input logic clr);
    we = we_i; waddr = wa; byteena = be; wdata = wd;
    re = re_i; raddr = ra; clear = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    $display("cyc t=%0t we=%0b wa=%0d be=%b wd=%h re=%0b ra=%0d clr=%0b -> rd4=%h rv4=%0b rm4=%b f4=%0b rd3=%h rv3=%0b f3=%0b",
             $time, we_i, wa, be, wd, re_i, ra, clr, rdata4, rvalid4, rmask4, full4,
             rdata3, rvalid3, full3);
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b0, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata4",  rdata4,  mrd[0]);
      chk("rmask4",  rmask4,  mrm[0]);
      chk("rvalid4", rvalid4, mrv[0]);
      chk("full4",   full4,   model_full(0));
      chk("rdata3",  rdata3,  mrd[1]);
      chk("rmask3",  rmask3,  mrm[1]);
      chk("rvalid3", rvalid3, mrv[1]);
      chk("full3",   full3,   model_full(1));
    end
  end

  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; byteena = '0; wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_rdata",  rdata4,  16'h0000);
    chk("rst_rvalid", rvalid4, 1'b0);
    chk("rst_rmask",  rmask4,  2'b00);
    chk("rst_full",   full4,   1'b0);
    chk_en = 1'b1;

    // Two partial writes merge per byte
    cyc(1'b1, 2'd0, 2'b01, 16'hBEEF, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd0, 2'b10, 16'h12AB, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd0, 1'b0);
    chk("merge_rdata",  rdata4,  16'h12EF);
    chk("merge_rmask",  rmask4,  2'b11);
    chk("merge_rvalid", rvalid4, 1'b1);
    idle();
    chk("hold_rvalid", rvalid4, 1'b0);
    chk("hold_rdata",  rdata4,  16'h12EF);

    // Same-cycle write and read see the written byte
    cyc(1'b1, 2'd2, 2'b01, 16'h5A5A, 1'b1, 2'd2, 1'b0);
    chk("bypass_rdata", rdata4, 16'h005A);
    chk("bypass_rmask", rmask4, 2'b01);

    // Async reset while a read result is presented
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd0, 1'b0);
    chk("pre_rst_rvalid", rvalid4, 1'b1);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rdata",  rdata4,  16'h0000);
    chk("async_rvalid", rvalid4, 1'b0);
    chk("async_rmask",  rmask4,  2'b00);
    model_reset();
    re = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd0, 1'b0);
    chk("post_rst_rdata", rdata4, 16'h0000);
    chk("post_rst_rmask", rmask4, 2'b00);

    // Fill every word, then clear with a colliding write
    cyc(1'b1, 2'd0, 2'b11, 16'h1111, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 2'b11, 16'h2222, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd2, 2'b11, 16'h3333, 1'b0, 2'd0, 1'b0);
    chk("full_before", full4, 1'b0);
    cyc(1'b1, 2'd3, 2'b11, 16'h4444, 1'b0, 2'd0, 1'b0);
    chk("full_after", full4, 1'b1);
    cyc(1'b1, 2'd1, 2'b11, 16'hFFFF, 1'b0, 2'd0, 1'b1);
    chk("full_clear", full4, 1'b0);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd1, 1'b0);
    chk("clear_rdata", rdata4, 16'h0000);
    cyc(1'b1, 2'd0, 2'b11, 16'h7777, 1'b1, 2'd0, 1'b1);
    chk("clear_bypass", rdata4, 16'h0000);

    // Out-of-range address on the DEPTH=3 bank
    cyc(1'b1, 2'd3, 2'b11, 16'hABCD, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd3, 1'b0);
    chk("oor_rdata3",  rdata3,  16'h0000);
    chk("oor_rvalid3", rvalid3, 1'b1);
    chk("oor_rmask3",  rmask3,  2'b00);
    chk("oor_rdata4",  rdata4,  16'hABCD);

    // Back-to-back reads a0..a3
    cyc(1'b1, 2'd0, 2'b11, 16'hA000, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 2'b11, 16'hA001, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd2, 2'b10, 16'hA002, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd0, 1'b0);
    chk("b2b_rd0", rdata4, 16'hA000);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd1, 1'b0);
    chk("b2b_rd1", rdata4, 16'hA001);
    chk("b2b_rv1", rvalid4, 1'b1);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd2, 1'b0);
    chk("b2b_rd2", rdata4, 16'hA000);
    chk("b2b_rm2", rmask4, 2'b10);
    cyc(1'b0, 2'd0, 2'b00, 16'h0000, 1'b1, 2'd3, 1'b0);
    chk("b2b_rd3", rdata4, 16'hABCD);
    chk("b2b_rd3_3", rdata3, 16'h0000);
    idle();
    chk("b2b_end_rv", rvalid4, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
